// File: rtl/vga_cipher_pkg.sv
// rtl/vga_cipher_pkg.sv - shared constants and mode encodings for the VGA cipher pipe
package vga_cipher_pkg;

    localparam logic [23:0] LFSR_POLY    = 24'hE10000;
    localparam logic [23:0] SEED_DEFAULT = 24'hACE1F0;
    localparam logic [23:0] BG_COLOR     = 24'h000000;

    typedef enum logic [1:0] {
        MODE_PLAIN = 2'b00,
        MODE_ENC   = 2'b01,
        MODE_RT    = 2'b10,
        MODE_KS    = 2'b11
    } mode_e;

endpackage

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - pixel/line counters, raw syncs, active flag and frame start pulse
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 29,
    parameter int HC_W     = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
    parameter int VC_W     = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic            clk,
    input  logic            rst,
    output logic [HC_W-1:0] hc,
    output logic [VC_W-1:0] vc,
    output logic            hsync_raw,
    output logic            vsync_raw,
    output logic            active,
    output logic            frame_start
);
    localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [HC_W-1:0] HC_LAST = HC_W'(HT - 1);
    localparam logic [VC_W-1:0] VC_LAST = VC_W'(VT - 1);
    localparam logic [HC_W-1:0] H_ACT   = HC_W'(H_ACTIVE);
    localparam logic [VC_W-1:0] V_ACT   = VC_W'(V_ACTIVE);
    localparam logic [HC_W-1:0] HS_BEG  = HC_W'(H_ACTIVE + H_FP);
    localparam logic [HC_W-1:0] HS_END  = HC_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VC_W-1:0] VS_BEG  = VC_W'(V_ACTIVE + V_FP);
    localparam logic [VC_W-1:0] VS_END  = VC_W'(V_ACTIVE + V_FP + V_SYNC);

    // Raster scan: hc runs across the line, vc steps when hc wraps
    always_ff @(posedge clk) begin
        if (rst) begin
            hc <= '0;
            vc <= '0;
        end else if (hc == HC_LAST) begin
            hc <= '0;
            vc <= (vc == VC_LAST) ? '0 : vc + 1'b1;
        end else begin
            hc <= hc + 1'b1;
        end
    end

    assign active      = (hc < H_ACT) && (vc < V_ACT);
    assign hsync_raw   = !((hc >= HS_BEG) && (hc < HS_END));
    assign vsync_raw   = !((vc >= VS_BEG) && (vc < VS_END));
    // Gated by rst so the pulse stays low while the counters are held at the origin
    assign frame_start = !rst && (hc == '0) && (vc == '0);

endmodule

// File: rtl/vga_cipher_pipe.sv
// rtl/vga_cipher_pipe.sv - VGA timing, windowed ROM fetch, LFSR XOR cipher and aligned RGB output
module vga_cipher_pipe
    import vga_cipher_pkg::*;
#(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 29,
    parameter int IMG_W      = 320,
    parameter int IMG_H      = 240,
    parameter int SCALE_LOG2 = 1,
    parameter int X0         = 0,
    parameter int Y0         = 0,
    parameter int ADDR_W     = 18,
    parameter int PIX_W      = 24,
    parameter int CH_BITS    = 3,
    parameter int RD_LAT     = 1,
    parameter int KEY_W      = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [KEY_W-1:0]   key,
    input  logic [1:0]         mode,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [PIX_W-1:0]   rom_data,
    output logic               hsync,
    output logic               vsync,
    output logic               vidon,
    output logic [CH_BITS-1:0] red,
    output logic [CH_BITS-1:0] green,
    output logic [CH_BITS-1:0] blue,
    output logic               frame_start
);
    localparam int HT     = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT     = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HC_W   = $clog2(HT);
    localparam int VC_W   = $clog2(VT);
    localparam int L      = RD_LAT + 2;
    localparam int FW     = PIX_W / 3;
    localparam int WIN_W  = IMG_W << SCALE_LOG2;
    localparam int WIN_H  = IMG_H << SCALE_LOG2;
    // Window clipped to the visible area so the line/row end always occurs
    localparam int WIN_WC = (WIN_W < H_ACTIVE - X0) ? WIN_W : H_ACTIVE - X0;
    localparam int WIN_HC = (WIN_H < V_ACTIVE - Y0) ? WIN_H : V_ACTIVE - Y0;

    localparam logic [HC_W-1:0] X0_C     = HC_W'(X0);
    localparam logic [VC_W-1:0] Y0_C     = VC_W'(Y0);
    localparam logic [HC_W-1:0] WIN_W_C  = HC_W'(WIN_WC);
    localparam logic [VC_W-1:0] WIN_H_C  = VC_W'(WIN_HC);
    localparam logic [HC_W-1:0] COL_LAST = HC_W'(WIN_WC - 1);
    localparam logic [VC_W-1:0] ROW_LAST = VC_W'(WIN_HC - 1);
    localparam logic [HC_W-1:0] SUB_H    = HC_W'((1 << SCALE_LOG2) - 1);
    localparam logic [VC_W-1:0] SUB_V    = VC_W'((1 << SCALE_LOG2) - 1);

    logic [HC_W-1:0]   hc, dx;
    logic [VC_W-1:0]   vc, dy;
    logic              hsync_raw, vsync_raw, active, in_win;
    logic [ADDR_W-1:0] col, row_base, addr_hold, addr_cur;
    logic [KEY_W-1:0]  lfsr, seed_sel, ks_now, ks_next;
    logic [KEY_W-1:0]  ks_pipe  [RD_LAT];
    logic              win_pipe [RD_LAT];
    logic              act_pipe [RD_LAT];
    logic [L-1:0]      hs_pipe, vs_pipe, vid_pipe;
    logic [PIX_W-1:0]  ks_pix, enc, dec, cipher_d, cipher_q;

    vga_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HC_W(HC_W), .VC_W(VC_W)
    ) u_timing (
        .clk(clk), .rst(rst), .hc(hc), .vc(vc),
        .hsync_raw(hsync_raw), .vsync_raw(vsync_raw),
        .active(active), .frame_start(frame_start)
    );

    assign dx       = hc - X0_C;
    assign dy       = vc - Y0_C;
    assign in_win   = active && (hc >= X0_C) && (dx < WIN_W_C) && (vc >= Y0_C) && (dy < WIN_H_C);
    assign addr_cur = row_base + col;
    assign rom_addr = in_win ? addr_cur : addr_hold;

    // Incremental address: column steps every 2^SCALE pixels, row base every 2^SCALE lines
    always_ff @(posedge clk) begin
        if (rst) begin
            col       <= '0;
            row_base  <= '0;
            addr_hold <= '0;
        end else if (in_win) begin
            addr_hold <= addr_cur;
            if (dx == COL_LAST) begin
                col <= '0;
                if (dy == ROW_LAST)
                    row_base <= '0;
                else if ((dy & SUB_V) == SUB_V)
                    row_base <= row_base + ADDR_W'(IMG_W);
            end else if ((dx & SUB_H) == SUB_H) begin
                col <= col + 1'b1;
            end
        end
    end

    // The frame-start pixel already uses the freshly loaded seed
    assign seed_sel = (key == '0) ? KEY_W'(SEED_DEFAULT) : key;
    assign ks_now   = frame_start ? seed_sel : lfsr;
    assign ks_next  = (ks_now >> 1) ^ (ks_now[0] ? KEY_W'(LFSR_POLY) : '0);

    // Keystream register: advances once per window pixel, reloads at frame start
    always_ff @(posedge clk) begin
        if (rst)
            lfsr <= KEY_W'(SEED_DEFAULT);
        else
            lfsr <= in_win ? ks_next : ks_now;
    end

    // Keystream and window/active flags delayed to meet the ROM data
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                ks_pipe[i]  <= '0;
                win_pipe[i] <= 1'b0;
                act_pipe[i] <= 1'b0;
            end
        end else begin
            ks_pipe[0]  <= ks_now;
            win_pipe[0] <= in_win;
            act_pipe[0] <= active;
            for (int i = 1; i < RD_LAT; i++) begin
                ks_pipe[i]  <= ks_pipe[i-1];
                win_pipe[i] <= win_pipe[i-1];
                act_pipe[i] <= act_pipe[i-1];
            end
        end
    end

    // Sync and video-on travel the full pipeline depth so they stay aligned with RGB
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_pipe  <= '1;
            vs_pipe  <= '1;
            vid_pipe <= '0;
        end else begin
            hs_pipe  <= {hs_pipe[L-2:0], hsync_raw};
            vs_pipe  <= {vs_pipe[L-2:0], vsync_raw};
            vid_pipe <= {vid_pipe[L-2:0], active};
        end
    end

    assign hsync  = hs_pipe[L-1];
    assign vsync  = vs_pipe[L-1];
    assign vidon  = vid_pipe[L-1];
    assign ks_pix = PIX_W'(ks_pipe[RD_LAT-1]);
    assign enc    = rom_data ^ ks_pix;
    assign dec    = enc ^ ks_pix;

    // Cipher select: blanking forces black, outside the window shows the background
    always_comb begin
        cipher_d = '0;
        if (act_pipe[RD_LAT-1] && !win_pipe[RD_LAT-1]) begin
            cipher_d = PIX_W'(BG_COLOR);
        end else if (act_pipe[RD_LAT-1]) begin
            case (mode_e'(mode))
                MODE_PLAIN: cipher_d = rom_data;
                MODE_ENC:   cipher_d = enc;
                MODE_RT:    cipher_d = dec;
                MODE_KS:    cipher_d = ks_pix;
                default:    cipher_d = rom_data;
            endcase
        end
    end

    // Cipher register followed by the channel-truncating output register
    always_ff @(posedge clk) begin
        if (rst) begin
            cipher_q <= '0;
            red      <= '0;
            green    <= '0;
            blue     <= '0;
        end else begin
            cipher_q <= cipher_d;
            red      <= cipher_q[3*FW-1 -: CH_BITS];
            green    <= cipher_q[2*FW-1 -: CH_BITS];
            blue     <= cipher_q[FW-1 -: CH_BITS];
        end
    end

endmodule

// File: tb/tb_vga_cipher_pipe.sv
// tb/tb_vga_cipher_pipe.sv - self-checking bench for vga_cipher_pipe on a reduced raster
module tb_vga_cipher_pipe;

    localparam int HT = 24;
    localparam int VT = 12;
    localparam int L  = 3;
    localparam int NF = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] key = 24'h5A5A5A;
    logic [1:0]  mode = 2'b00;
    logic [17:0] rom_addr;
    logic [23:0] rom_data;
    logic        hsync, vsync, vidon, frame_start;
    logic [2:0]  red, green, blue;

    vga_cipher_pipe #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .IMG_W(6), .IMG_H(3), .SCALE_LOG2(1), .X0(2), .Y0(1),
        .ADDR_W(18), .PIX_W(24), .CH_BITS(3), .RD_LAT(1), .KEY_W(24)
    ) dut (
        .clk(clk), .rst(rst), .key(key), .mode(mode),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .hsync(hsync), .vsync(vsync), .vidon(vidon),
        .red(red), .green(green), .blue(blue),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] rom_fn(input logic [17:0] a);
        logic [23:0] x;
        x = {6'd0, a};
        return x * 24'h2F1B3D + 24'h5A17C3;
    endfunction

    always @(posedge clk) rom_data <= rom_fn(rom_addr);

    function automatic logic [23:0] tb_step(input logic [23:0] s);
        logic fb;
        fb = s[0];
        s  = s >> 1;
        if (fb) s = s ^ 24'hE10000;
        return s;
    endfunction

    typedef struct {
        logic        hs, vs, act, win;
        logic [23:0] pix, ks;
        int          f, idx;
    } ent_t;

    typedef struct {
        int          x, y;
        logic [17:0] addr;
    } vec_t;

    ent_t        sb[$];
    vec_t        tbl[9];
    logic [8:0]  cap [NF][HT*VT];
    int          n_cmp = 0, n_err = 0;
    int          mhc = 0, mvc = 0, fidx = 0, cyc = 0;
    logic [17:0] m_hold = '0;
    logic [23:0] m_lfsr = 24'hACE1F0;
    logic [1:0]  mh0 = 2'b00, mh1 = 2'b00, mh2 = 2'b00;
    logic        prev_hs = 1'b1;
    int          fall0 = -1, rise0 = -1, fall1 = -1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t hc=%0d vc=%0d frame=%0d)", nm, got, exp, $time, mhc, mvc, fidx);
        end
    endtask

    task automatic model_reset();
        ent_t e;
        sb.delete();
        e.hs = 1'b1; e.vs = 1'b1; e.act = 1'b0; e.win = 1'b0;
        e.pix = '0; e.ks = '0; e.f = -1; e.idx = 0;
        for (int i = 0; i < L; i++) sb.push_back(e);
        mhc = 0; mvc = 0; m_hold = '0;
    endtask

    task automatic model_push();
        logic act, win, fs;
        logic [17:0] a;
        ent_t e;
        act = (mhc < 16) && (mvc < 8);
        win = act && (mhc >= 2) && (mhc < 14) && (mvc >= 1) && (mvc < 7);
        fs  = (mhc == 0) && (mvc == 0);
        chk("frame_start", frame_start, fs);
        if (fs) m_lfsr = (key == 24'd0) ? 24'hACE1F0 : key;
        if (win) begin
            a = 18'(((mvc - 1) / 2) * 6 + (mhc - 2) / 2);
            m_hold = a;
        end else begin
            a = m_hold;
        end
        chk("rom_addr", rom_addr, a);
        foreach (tbl[i])
            if (tbl[i].x == mhc && tbl[i].y == mvc) chk("tbl_addr", rom_addr, tbl[i].addr);
        e.hs  = !((mhc >= 18) && (mhc < 21));
        e.vs  = !((mvc >= 9) && (mvc < 11));
        e.act = act;
        e.win = win;
        e.pix = rom_fn(a);
        e.ks  = m_lfsr;
        e.f   = fidx;
        e.idx = mvc * HT + mhc;
        sb.push_back(e);
        if (win) m_lfsr = tb_step(m_lfsr);
    endtask

    task automatic pop_cmp();
        ent_t e;
        logic [23:0] w;
        logic [8:0] ex;
        e = sb.pop_front();
        if (!e.act || !e.win) w = '0;
        else begin
            case (mh2)
                2'd0:    w = e.pix;
                2'd1:    w = e.pix ^ e.ks;
                2'd2:    w = e.pix;
                default: w = e.ks;
            endcase
        end
        ex = {w[23:21], w[15:13], w[7:5]};
        chk("hsync", hsync, e.hs);
        chk("vsync", vsync, e.vs);
        chk("vidon", vidon, e.act);
        chk("rgb", {red, green, blue}, ex);
        if (e.f >= 0 && e.f < NF) cap[e.f][e.idx] = {red, green, blue};
    endtask

    task automatic set_inputs();
        rst = 1'b0;
        case (fidx)
            0: begin mode = 2'b00; key = 24'h5A5A5A; end
            1: begin mode = 2'b10; key = 24'h5A5A5A; end
            2: begin mode = 2'b01; key = 24'h5A5A5A; end
            3: begin mode = 2'b11; key = 24'h000000; end
            4: begin mode = 2'b01; key = 24'h000001; end
            5: begin mode = 2'b01; key = (mvc >= 4) ? 24'hFFFFFF : 24'h000001; end
            6: begin mode = 2'b01; key = 24'hFFFFFF; end
            7: begin
                key  = 24'h5A5A5A;
                mode = (mvc == 2 && mhc >= 6 && mhc < 9) ? 2'b01 :
                       ((mvc == 3 && mhc == 5) ? 2'b11 : 2'b00);
            end
            8: begin mode = 2'b01; key = 24'h000001; rst = (mhc == 10 && mvc == 4); end
            default: begin mode = 2'b01; key = 24'h000001; end
        endcase
    endtask

    task automatic run_cycle();
        @(negedge clk);
        mh2 = mh1; mh1 = mh0; mh0 = mode;
        if (rst) begin
            chk("frame_start_in_rst", frame_start, 1'b0);
            if (sb.size() > 0) pop_cmp();
            model_reset();
            fidx++;
        end else begin
            if (cyc < 100) begin
                if (prev_hs && !hsync) begin
                    if (fall0 < 0) fall0 = cyc;
                    else if (fall1 < 0) fall1 = cyc;
                end
                if (!prev_hs && hsync && rise0 < 0) rise0 = cyc;
                prev_hs = hsync;
            end
            model_push();
            pop_cmp();
            mhc++;
            if (mhc == HT) begin
                mhc = 0;
                mvc++;
                if (mvc == VT) begin
                    mvc = 0;
                    fidx++;
                end
            end
            cyc++;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic int frame_diff(input int fa, input int fb);
        int n;
        n = 0;
        for (int i = 0; i < HT * VT; i++)
            if (cap[fa][i] !== cap[fb][i]) n++;
        return n;
    endfunction

    initial begin
        int guard, nd;
        tbl[0] = '{2, 1, 18'd0};
        tbl[1] = '{3, 1, 18'd0};
        tbl[2] = '{4, 1, 18'd1};
        tbl[3] = '{13, 1, 18'd5};
        tbl[4] = '{2, 3, 18'd6};
        tbl[5] = '{5, 4, 18'd7};
        tbl[6] = '{13, 6, 18'd17};
        tbl[7] = '{15, 6, 18'd17};
        tbl[8] = '{0, 7, 18'd17};

        rst = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("rst_hsync", hsync, 1'b1);
            chk("rst_vsync", vsync, 1'b1);
            chk("rst_vidon", vidon, 1'b0);
            chk("rst_rgb", {red, green, blue}, 9'd0);
            chk("rst_frame_start", frame_start, 1'b0);
            chk("rst_rom_addr", rom_addr, 18'd0);
        end
        rst = 1'b0;
        model_reset();
        fidx = 0;

        guard = 0;
        while (fidx < NF && guard < 4000) begin
            set_inputs();
            run_cycle();
            guard++;
        end
        chk("run_bound", (fidx >= NF), 1'b1);
        for (int i = 0; i < L; i++) begin
            set_inputs();
            run_cycle();
        end

        chk("hsync_first_fall", fall0, 21);
        chk("hsync_first_rise", rise0, 24);
        chk("hsync_second_fall", fall1, 45);

        chk("roundtrip_eq_plain", frame_diff(1, 0), 0);
        for (int y = 1; y < 7; y++) begin
            nd = 0;
            for (int x = 2; x < 14; x++)
                if (cap[2][y*HT+x] !== cap[0][y*HT+x]) nd++;
            chk("enc_line_differs", (nd > 0), 1'b1);
        end
        chk("ks_seed_red", cap[3][1*HT+2][8:6], 3'b101);
        chk("key_midframe_ignored", frame_diff(5, 4), 0);
        chk("new_key_next_frame", (frame_diff(6, 4) > 0), 1'b1);
        chk("post_reset_eq_cold", frame_diff(9, 4), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vga_cipher_pipe.md
Name: vga_cipher_pipe

Overview:
Parametrised successor to the fixed 640x480 image path. One pixel-clock block that combines:
- VGA timing generation with configurable porches.
- Windowed and scaled ROM address generation.
- An LFSR keystream XOR cipher with selectable display modes.
- Pipeline alignment of sync/vidon to the synchronous-ROM read latency.

It sits between the clock-wizard pixel clock and the board RGB pins, and replaces the separate timing driver, image fetch and encryption instances.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porches and sync width (line total 800)
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 29, vertical porches and sync width (frame total 521)
- IMG_W / IMG_H, 320 / 240, source image size in ROM
- SCALE_LOG2, 1, pixel replication factor 2^SCALE_LOG2 (range 0..2)
- X0 / Y0, 0 / 0, window origin in active coordinates
- ADDR_W, 18, ROM address width
- PIX_W, 24, ROM word width {R8,G8,B8}
- CH_BITS, 3, output bits per colour channel (1..8)
- RD_LAT, 1, ROM read latency in cycles (1..3)
- KEY_W, 24, key and LFSR width

Ports:
- clk  in  1  pixel clock (25 MHz)
- rst  in  1  synchronous, active-high reset
- key  in  KEY_W  cipher key; sampled only at frame start
- mode  in  2  00 plain, 01 encrypted, 10 encrypt-then-decrypt, 11 raw keystream
- rom_addr  out  ADDR_W  ROM read address
- rom_data  in  PIX_W  ROM data, valid RD_LAT cycles after the address
- hsync  out  1  active-low horizontal sync, pipeline-aligned
- vsync  out  1  active-low vertical sync, pipeline-aligned
- vidon  out  1  active-video flag, pipeline-aligned
- red / green / blue  out  CH_BITS each  colour outputs
- frame_start  out  1  one-cycle pulse when hc=0 and vc=0 (counter domain, unaligned)

Behaviour:
Reset:
- hc=vc=0, rom_addr=0, lfsr=SEED_DEFAULT.
- hsync=vsync=1, vidon=0, rgb=0, frame_start=0.
- All delay-line stages are cleared to the inactive value.
- Reset mid-frame restarts at hc=vc=0 on the next cycle.

Counters:
- hc counts 0..HT-1 with HT = sum of the horizontal params.
- vc increments when hc wraps; vc wraps at VT-1.
- Active region: hc<H_ACTIVE and vc<V_ACTIVE.
- Raw hsync is low for hc in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vsync is the vertical equivalent.

Window:
- in_win = active && hc-X0 in [0, IMG_W<<SCALE_LOG2) && vc-Y0 in [0, IMG_H<<SCALE_LOG2).
- rom_addr = ((vc-Y0)>>SCALE_LOG2)*IMG_W + ((hc-X0)>>SCALE_LOG2).
- Generate it incrementally with a row-base register, no multiplier:
  - The column part steps every 2^SCALE_LOG2 in-window pixels.
  - The row base adds IMG_W every 2^SCALE_LOG2 window lines.
- Outside the window rom_addr holds its last value.

Key and LFSR:
- At frame_start, the key register loads key; the LFSR loads key, or SEED_DEFAULT if key==0.
- key changes mid-frame take effect only at the next frame.
- The LFSR advances one Galois step on every in_win cycle and holds otherwise.
- The keystream word is delayed RD_LAT cycles so it meets its rom_data.

Cipher stage (1 register):
- enc = rom_data ^ ks; dec = enc ^ ks.
- The stage selects by mode: 00 rom_data, 01 enc, 10 dec, 11 ks.
- Outside the window it outputs BG_COLOR; during blanking it outputs 0.

Output stage (1 register):
- Each channel is the top CH_BITS bits of its 8-bit field.

Latency:
- L = RD_LAT+2 cycles from counter value to rgb.
- hsync, vsync and vidon pass through L-deep shift registers, so sync and colour stay aligned.

Boundary cases:
- mode change mid-line applies at the cipher register on the next cycle.
- frame_start coinciding with the last in_win cycle is impossible (blanking precedes it); no special handling.

Decomposition:
- Package vga_cipher_pkg holds:
  - LFSR_POLY (24'hE10000 taps x^24+x^23+x^22+x^17+1).
  - SEED_DEFAULT (24'hACE1F0) and BG_COLOR (24'h000000).
  - Mode encodings MODE_PLAIN, MODE_ENC, MODE_RT, MODE_KS.
- Sub-module vga_timing_gen holds hc/vc, raw sync, active and frame_start.
- Address generation, LFSR, cipher and alignment stay in the top.

Test Plan:
1. Reset held 3 cycles then released -> hsync=vsync=1 and rgb=0 during reset. First hsync fall at counter hc=656, visible at the pin L=3 cycles later. Low for 96 cycles; line period 800, frame period 416800 cycles.
2. mode=00, ROM model returns addr as data -> rom_addr sequence at pixels (0,0),(1,0),(2,0),(0,2) is 0,0,1,320. red at pin = data[23:21] 3 cycles after each address.
3. mode=10 with key=24'h5A5A5A over a full frame -> every rgb equals the mode=00 output. mode=01 differs from plain on at least one pixel per line.
4. key=0, mode=11 -> first in-window rgb derives from SEED_DEFAULT (red=3'b101). Nonzero stream continues; LFSR never locks at 0.
5. key switched from 24'h000001 to 24'hFFFFFF at line 100 -> frame output identical to the unchanged-key frame. New stream appears only after the next frame_start.
6. rst asserted at hc=300, vc=200 for 1 cycle -> next cycle hc=vc=0 and all delay stages are inactive. The frame then repeats identically to a cold start.
